wb_rx_writer: RTL and testbench

- Wishbone initiator (master) that moves received Ethernet frame bytes into the SoC address space.
- Packs the RX byte stream into little-endian 32-bit words and buffers them in a small FIFO.
- Writes the words with single classic-cycle writes to a linear frame buffer, then writes the frame length to a status register.
- Sits between the RX datapath and the Wishbone bus, as the counterpart to the CSR responder.

---
 rtl/wb_rx_writer.sv | 277 +++++++++++++++++++++++++++
 tb/tb_wb_rx_writer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_rx_writer.sv
// Wishbone initiator: packs RX bytes into LE 32-bit words, writes them to a linear frame buffer, then writes the frame length.
// Latency: a word is pushed on its 4th byte (or rx_last); the bus write starts one cycle after the pop; one idle cycle separates writes.
// Backpressure: none toward RX; when the FIFO is full or the buffer is exhausted, data is dropped and overflow is set.
module wb_rx_writer #(
  parameter int          OCT         = 8,
  parameter logic [31:0] BUF_BASE    = 32'h3000_1000,
  parameter int          BUF_WORDS   = 384,
  parameter logic [31:0] LEN_ADDR    = 32'h3000_0010,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          ACK_TIMEOUT = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [OCT-1:0]   rx_data,
  input  logic             rx_valid,
  input  logic             rx_last,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  output logic [4*OCT-1:0] wbm_dat_o,
  input  logic             wbm_ack_i,
  output logic             frame_done,
  output logic [15:0]      frame_len,
  output logic             overflow,
  output logic             timeout,
  input  logic             err_clr
);

  localparam int DW  = 4 * OCT;
  localparam int EW  = 1 + 4 + DW + 16;           // {last, sel, data, len}
  localparam int WIW = $clog2(BUF_WORDS + 1);
  localparam int TW  = $clog2(ACK_TIMEOUT + 1);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;

  typedef enum logic [1:0] {IDLE, DATA, LEN} state_t;

  // ---------------- packer ----------------
  logic [1:0]     bi_q, bi_d;
  logic [DW-1:0]  acc_q, acc_d, data_w;
  logic [3:0]     accs_q, accs_d, sel_w;
  logic [15:0]    blen_q, blen_d, cnt_w;
  logic [WIW-1:0] wcnt_q, wcnt_d;
  logic           push_req, drop_byte;
  logic [EW-1:0]  push_ent;

  // ---------------- fifo ----------------
  logic [EW-1:0]  mem [FIFO_DEPTH];
  logic [PW-1:0]  wptr_q, rptr_q;
  logic [CW-1:0]  fcnt_q;
  logic           push_ok, pop, ovf_set;
  logic [EW-1:0]  head;

  // ---------------- master ----------------
  state_t         state_q, state_d;
  logic           stb_q, stb_d;
  logic [31:0]    adr_q, adr_d;
  logic [DW-1:0]  dat_q, dat_d;
  logic [3:0]     sel_q, sel_d;
  logic           last_q, last_d;
  logic [15:0]    elen_q, elen_d;
  logic [WIW-1:0] widx_q, widx_d;
  logic [TW-1:0]  tcnt_q, tcnt_d;
  logic           done_d;
  logic [15:0]    flen_d;
  logic           bus_end, to_set;

  // Lane-insert the incoming byte, decide whether a word (or a bare last marker) is emitted.
  always_comb begin
    bi_d      = bi_q;
    acc_d     = acc_q;
    accs_d    = accs_q;
    blen_d    = blen_q;
    wcnt_d    = wcnt_q;
    push_req  = 1'b0;
    push_ent  = '0;
    drop_byte = 1'b0;
    data_w    = acc_q;
    sel_w     = accs_q;
    for (int l = 0; l < 4; l++) begin
      if (bi_q == 2'(l)) begin
        data_w[l*OCT +: OCT] = rx_data;
        sel_w[l]             = 1'b1;
      end
    end
    cnt_w = (blen_q == 16'hFFFF) ? 16'hFFFF : blen_q + 16'd1;
    if (rx_valid) begin
      blen_d = cnt_w;
      if (wcnt_q == WIW'(BUF_WORDS)) begin
        // Buffer exhausted: byte is lost, but the frame still closes with a length write.
        drop_byte = 1'b1;
        if (rx_last) begin
          push_req = 1'b1;
          push_ent = {1'b1, 4'h0, {DW{1'b0}}, cnt_w};
        end
      end else if (bi_q == 2'd3 || rx_last) begin
        push_req = 1'b1;
        push_ent = {rx_last, sel_w, data_w, cnt_w};
        wcnt_d   = wcnt_q + WIW'(1);
        bi_d     = 2'd0;
        acc_d    = '0;
        accs_d   = '0;
      end else begin
        bi_d   = bi_q + 2'd1;
        acc_d  = data_w;
        accs_d = sel_w;
      end
      if (rx_last) begin
        blen_d = '0;
        wcnt_d = '0;
        bi_d   = 2'd0;
        acc_d  = '0;
        accs_d = '0;
      end
    end
  end

  // The last FIFO slot is kept for frame-closing entries so a length write is rarely lost.
  assign push_ok = push_req &&
                   ((fcnt_q < CW'(FIFO_DEPTH - 1)) || (push_ent[EW-1] && (fcnt_q < CW'(FIFO_DEPTH))));
  assign ovf_set = drop_byte || (push_req && !push_ok);
  assign head    = mem[rptr_q];

  // Packer state registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      bi_q   <= 2'd0;
      acc_q  <= '0;
      accs_q <= '0;
      blen_q <= '0;
      wcnt_q <= '0;
    end else begin
      bi_q   <= bi_d;
      acc_q  <= acc_d;
      accs_q <= accs_d;
      blen_q <= blen_d;
      wcnt_q <= wcnt_d;
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge wb_clk_i) begin
    if (push_ok) mem[wptr_q] <= push_ent;
  end

  // FIFO pointers and occupancy; simultaneous push and pop both take effect.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      fcnt_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PW'(1);
      if (pop)     rptr_q <= rptr_q + PW'(1);
      case ({push_ok, pop})
        2'b10:   fcnt_q <= fcnt_q + CW'(1);
        2'b01:   fcnt_q <= fcnt_q - CW'(1);
        default: fcnt_q <= fcnt_q;
      endcase
    end
  end

  // Master next-state and next-output logic; bus outputs are registered so they hold until ack.
  always_comb begin
    state_d = state_q;
    stb_d   = stb_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    last_d  = last_q;
    elen_d  = elen_q;
    widx_d  = widx_q;
    tcnt_d  = tcnt_q;
    done_d  = 1'b0;
    flen_d  = frame_len;
    pop     = 1'b0;
    // An ack seen while stb is low is a stray and is not looked at.
    bus_end = stb_q && (wbm_ack_i || (tcnt_q == TW'(ACK_TIMEOUT - 1)));
    to_set  = stb_q && !wbm_ack_i && (tcnt_q == TW'(ACK_TIMEOUT - 1));
    if (stb_q && !bus_end) tcnt_d = tcnt_q + TW'(1);
    case (state_q)
      IDLE: begin
        if (fcnt_q != '0) begin
          pop    = 1'b1;
          last_d = head[EW-1];
          elen_d = head[15:0];
          if (head[EW-2 -: 4] != 4'h0) begin
            stb_d   = 1'b1;
            adr_d   = BUF_BASE + 32'({widx_q, 2'b00});
            dat_d   = head[16 +: DW];
            sel_d   = head[EW-2 -: 4];
            tcnt_d  = '0;
            state_d = DATA;
          end else if (head[EW-1]) begin
            state_d = LEN;
          end
        end
      end
      DATA: begin
        if (bus_end) begin
          stb_d   = 1'b0;
          widx_d  = widx_q + WIW'(1);
          state_d = last_q ? LEN : IDLE;
        end
      end
      LEN: begin
        if (!stb_q) begin
          // Entering LEN always leaves stb low for a cycle, giving the required gap.
          stb_d  = 1'b1;
          adr_d  = LEN_ADDR;
          dat_d  = DW'({16'h0, elen_q});
          sel_d  = 4'hF;
          tcnt_d = '0;
        end else if (bus_end) begin
          stb_d   = 1'b0;
          flen_d  = elen_q;
          done_d  = 1'b1;
          widx_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Master state and bus output registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      stb_q      <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      last_q     <= 1'b0;
      elen_q     <= '0;
      widx_q     <= '0;
      tcnt_q     <= '0;
      frame_done <= 1'b0;
      frame_len  <= '0;
    end else begin
      state_q    <= state_d;
      stb_q      <= stb_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      elen_q     <= elen_d;
      widx_q     <= widx_d;
      tcnt_q     <= tcnt_d;
      frame_done <= done_d;
      frame_len  <= flen_d;
    end
  end

  // Sticky error flags; a new error in the same cycle beats the clear.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      overflow <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      if (ovf_set)      overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;
      if (to_set)       timeout  <= 1'b1;
      else if (err_clr) timeout  <= 1'b0;
    end
  end

  assign wbm_cyc_o = stb_q;
  assign wbm_stb_o = stb_q;
  assign wbm_we_o  = stb_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;

endmodule

// File: tb/tb_wb_rx_writer.sv
// Testbench for wb_rx_writer: drives RX frames, models a Wishbone responder with programmable ack delay,
// and checks every bus write against a scoreboard filled as the bytes are driven.
module tb_wb_rx_writer;

  localparam logic [31:0] BUF_BASE  = 32'h3000_1000;
  localparam logic [31:0] LEN_ADDR  = 32'h3000_0010;
  localparam int          BUF_WORDS = 384;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h0;
  logic        rx_valid = 1'b0;
  logic        rx_last = 1'b0;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat;
  logic        ack;
  logic        frame_done;
  logic [15:0] frame_len;
  logic        overflow, timeout;
  logic        err_clr = 1'b0;

  int  tests = 0;
  int  fails = 0;
  wr_t sb[$];

  int   ack_delay = 0;
  logic ack_en = 1'b1;
  int   ack_wait = 0;

  always #5 clk = ~clk;

  wb_rx_writer dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_last   (rx_last),
    .wbm_cyc_o (cyc),
    .wbm_stb_o (stb),
    .wbm_we_o  (we),
    .wbm_sel_o (sel),
    .wbm_adr_o (adr),
    .wbm_dat_o (dat),
    .wbm_ack_i (ack),
    .frame_done(frame_done),
    .frame_len (frame_len),
    .overflow  (overflow),
    .timeout   (timeout),
    .err_clr   (err_clr)
  );

  // Responder: acks after ack_delay wait cycles, or never when disabled.
  always @(posedge clk) begin
    if (stb && !ack) ack_wait <= ack_wait + 1;
    else             ack_wait <= 0;
  end
  assign ack = ack_en && cyc && stb && (ack_wait >= ack_delay);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_t e;
    e.adr = a;
    e.dat = d;
    e.sel = s;
    sb.push_back(e);
  endtask

  // Bus monitor: one record per stb-high period, finalized when stb is seen low again.
  logic        in_txn = 1'b0;
  logic        unstable;
  int          dur;
  logic [31:0] t_adr, t_dat;
  logic [3:0]  t_sel;
  always @(negedge clk) begin
    if (rst) begin
      in_txn = 1'b0;
    end else if (stb) begin
      if (!in_txn) begin
        in_txn   = 1'b1;
        dur      = 0;
        unstable = 1'b0;
        t_adr    = adr;
        t_dat    = dat;
        t_sel    = sel;
      end else if (adr !== t_adr || dat !== t_dat || sel !== t_sel) begin
        unstable = 1'b1;
      end
      if (!cyc || !we) unstable = 1'b1;
      dur++;
    end else if (in_txn) begin
      wr_t e;
      in_txn = 1'b0;
      chk("wr_stable", 64'(unstable), 64'd0);
      chk("wr_stb_cycles", 64'(dur), ack_en ? 64'(ack_delay + 1) : 64'd255);
      if (sb.size() == 0) begin
        chk("sb_unexpected_write", 64'(t_adr), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("wr_adr", 64'(t_adr), 64'(e.adr));
        chk("wr_dat", 64'(t_dat), 64'(e.dat));
        chk("wr_sel", 64'(t_sel), 64'(e.sel));
      end
    end
  end

  // Drives an n-byte frame 01,02,... at one byte per cycle and queues the writes it should cause.
  task automatic send_frame(input int n);
    logic [31:0] w;
    logic [3:0]  s;
    int          bi;
    int          widx;
    logic [15:0] len;
    w = '0; s = '0; bi = 0; widx = 0;
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      b = 8'(i + 1);
      @(posedge clk); #1;
      rx_data  = b;
      rx_valid = 1'b1;
      rx_last  = (i == n - 1);
      if (widx < BUF_WORDS) begin
        w[8*bi +: 8] = b;
        s[bi]        = 1'b1;
        if (bi == 3 || i == n - 1) begin
          sb_push(BUF_BASE + 32'(4 * widx), w, s);
          widx++;
          w = '0; s = '0; bi = 0;
        end else begin
          bi++;
        end
      end
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_last  = 1'b0;
    len = (n > 65535) ? 16'hFFFF : 16'(n);
    sb_push(LEN_ADDR, {16'h0, len}, 4'hF);
  endtask

  // Waits (bounded) for frame_done, then checks length, pulse width and scoreboard drain.
  task automatic wait_done(input logic [15:0] exp_len, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < budget);
    chk("done_seen", 64'(frame_done), 64'd1);
    chk("frame_len", 64'(frame_len), 64'(exp_len));
    @(negedge clk);
    chk("done_pulse", 64'(frame_done), 64'd0);
    @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  task automatic clear_errors();
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
  endtask

  initial begin
    int n;
    #1;
    chk("rst_cyc", 64'(cyc), 64'd0);
    chk("rst_stb", 64'(stb), 64'd0);
    chk("rst_done", 64'(frame_done), 64'd0);
    chk("rst_len", 64'(frame_len), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_tmo", 64'(timeout), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Full words, zero-wait ack.
    ack_en = 1'b1; ack_delay = 0;
    send_frame(8);
    wait_done(16'd8, 200);

    // Partial last word.
    send_frame(5);
    wait_done(16'd5, 200);

    // Slow responder.
    ack_delay = 3;
    send_frame(16);
    wait_done(16'd16, 300);
    chk("ovf_16", 64'(overflow), 64'd0);
    chk("tmo_16", 64'(timeout), 64'd0);

    // Responder never acks: every write times out but all are still issued.
    ack_en = 1'b0;
    send_frame(8);
    wait_done(16'd8, 2000);
    chk("tmo_set", 64'(timeout), 64'd1);
    ack_en = 1'b1; ack_delay = 0;
    clear_errors();
    chk("tmo_clr", 64'(timeout), 64'd0);

    // Frame larger than the buffer.
    send_frame(1540);
    wait_done(16'd1540, 3000);
    chk("ovf_set", 64'(overflow), 64'd1);
    clear_errors();
    chk("ovf_clr", 64'(overflow), 64'd0);

    // Reset mid-write, without a clock edge.
    ack_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      rx_data  = 8'hA0 + 8'(i);
      rx_valid = 1'b1;
      rx_last  = (i == 3);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_last  = 1'b0;
    n = 0;
    while (!stb && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("pre_rst_stb", 64'(stb), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_cyc", 64'(cyc), 64'd0);
    chk("arst_stb", 64'(stb), 64'd0);
    chk("arst_done", 64'(frame_done), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ack_en = 1'b1; ack_delay = 0;
    send_frame(4);
    wait_done(16'd4, 200);

    chk("sb_final", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
